a23_copro_mp: RTL and testbench

A23_COPRO_MP -- requirements
Module: a23_copro_mp

---
 rtl/a23_copro_mp.sv | 224 ++++++++++++++++++++++
 tb/tb_a23_copro_mp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a23_copro_mp.sv
// a23_copro_mp: system-control coprocessor for the A23 core.
// Provides CPU ID, cache control, region flags, a fault record and a
// cache-flush handshake over a simple MRC/MCR register port.
// Optional build macro: A23_COPRO_FAULT_FIFO_EN
//   defined   -> fault capture is a FAULT_DEPTH-entry FIFO with sticky overflow
//   undefined -> fault capture is a single entry that every new fault overwrites
module a23_copro_mp #(
  parameter int          AREA_W      = 32,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] CPU_ID      = 32'h4156_0300
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_stall,
  input  logic [1:0]        i_copro_operation,
  input  logic [3:0]        i_copro_crn,
  input  logic [31:0]       i_copro_write_data,
  input  logic              i_fault,
  input  logic [7:0]        i_fault_status,
  input  logic [31:0]       i_fault_address,
  input  logic              i_cache_flush_done,
  output logic [31:0]       o_copro_read_data,
  output logic              o_cache_enable,
  output logic              o_cache_flush,
  output logic [AREA_W-1:0] o_cacheable_area,
  output logic [AREA_W-1:0] o_updateable_area,
  output logic [AREA_W-1:0] o_disruptive_area,
  output logic              o_fault_pending
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  logic [2:0]        cache_control;
  logic [AREA_W-1:0] cacheable_area;
  logic [AREA_W-1:0] updateable_area;
  logic [AREA_W-1:0] disruptive_area;
  logic              overflow;
  flush_state_t      flush_state;
  logic              flush_busy;
  logic [31:0]       read_mux;

  // Fault-record view shared by both capture implementations
  logic [7:0]        head_status;
  logic [31:0]       head_address;
  logic [7:0]        fault_count;
  logic              fault_nonempty;
  logic              ovf_set;

  // Register-port decode; a stalled cycle accepts nothing
  logic active;
  logic mcr;
  logic mrc;
  logic push;
  logic pop;

  assign active = ~i_fetch_stall;
  assign mcr    = active && (i_copro_operation == OP_MCR);
  assign mrc    = active && (i_copro_operation == OP_MRC);
  assign push   = active && i_fault;
  assign pop    = mrc && (i_copro_crn == 4'd7) && fault_nonempty;

  // Control registers written by MCR
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cache_control   <= '0;
      cacheable_area  <= '0;
      updateable_area <= '0;
      disruptive_area <= '0;
    end else if (mcr) begin
      case (i_copro_crn)
        4'd2:    cache_control   <= i_copro_write_data[2:0];
        4'd3:    cacheable_area  <= i_copro_write_data[AREA_W-1:0];
        4'd4:    updateable_area <= i_copro_write_data[AREA_W-1:0];
        4'd5:    disruptive_area <= i_copro_write_data[AREA_W-1:0];
        default: ;
      endcase
    end
  end

  // Sticky overflow: a dropped fault sets it, MCR CRn8 clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (mcr && (i_copro_crn == 4'd8)) begin
      overflow <= 1'b0;
    end
  end

`ifdef A23_COPRO_FAULT_FIFO_EN
  localparam int PTR_W = (FAULT_DEPTH > 1) ? $clog2(FAULT_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_COUNT = FAULT_DEPTH[PTR_W:0];

  logic [7:0]       fifo_status  [FAULT_DEPTH];
  logic [31:0]      fifo_address [FAULT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push_accept;

  assign full           = (count == DEPTH_COUNT);
  assign fault_nonempty = (count != '0);
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts
  assign push_accept    = push && (!full || pop);
  assign ovf_set        = push && full && !pop;

  // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)         rd_ptr <= rd_ptr + 1'b1;
      case ({push_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Fault entry storage
  // NOTE: storage has no reset; validity comes from the reset pointers and count.
  always_ff @(posedge i_clk) begin
    if (push_accept) begin
      fifo_status[wr_ptr]  <= i_fault_status;
      fifo_address[wr_ptr] <= i_fault_address;
    end
  end

  assign head_status  = fault_nonempty ? fifo_status[rd_ptr]  : 8'd0;
  assign head_address = fault_nonempty ? fifo_address[rd_ptr] : 32'd0;
  assign fault_count  = 8'(count);
`else
  logic        fault_valid;
  logic [7:0]  single_status;
  logic [31:0] single_address;

  assign fault_nonempty = fault_valid;
  assign ovf_set        = 1'b0;

  // Valid flag: a new fault wins over a simultaneous CRn7 read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_valid <= 1'b0;
    end else if (push) begin
      fault_valid <= 1'b1;
    end else if (pop) begin
      fault_valid <= 1'b0;
    end
  end

  // Single fault record, overwritten by every accepted fault
  always_ff @(posedge i_clk) begin
    if (push) begin
      single_status  <= i_fault_status;
      single_address <= i_fault_address;
    end
  end

  assign head_status  = fault_valid ? single_status  : 8'd0;
  assign head_address = fault_valid ? single_address : 32'd0;
  assign fault_count  = {7'd0, fault_valid};
`endif

  // Read map, sampled before any pop this cycle takes effect
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    read_mux = 32'd0;
    case (i_copro_crn)
      4'd0:    read_mux = CPU_ID;
      4'd2:    read_mux = {29'd0, cache_control};
      4'd3:    read_mux = 32'(cacheable_area);
      4'd4:    read_mux = 32'(updateable_area);
      4'd5:    read_mux = 32'(disruptive_area);
      4'd6:    read_mux = {16'd0, fault_count, head_status};
      4'd7:    read_mux = head_address;
      4'd8:    read_mux = {30'd0, flush_busy, overflow};
      default: read_mux = 32'd0;
    endcase
  end

  // Read data register: one-cycle latency, frozen while stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_copro_read_data <= 32'd0;
    end else if (active) begin
      o_copro_read_data <= read_mux;
    end
  end

  // Cache flush handshake; the acknowledge is honoured even during a stall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_state <= ST_IDLE;
    end else begin
      case (flush_state)
        ST_IDLE:  if (mcr && (i_copro_crn == 4'd1)) flush_state <= ST_FLUSH;
        ST_FLUSH: if (i_cache_flush_done)           flush_state <= ST_IDLE;
        default:  flush_state <= ST_IDLE;
      endcase
    end
  end

  assign flush_busy        = (flush_state == ST_FLUSH);
  assign o_cache_flush     = flush_busy;
  assign o_cache_enable    = cache_control[0];
  assign o_cacheable_area  = cacheable_area;
  assign o_updateable_area = updateable_area;
  assign o_disruptive_area = disruptive_area;
  assign o_fault_pending   = fault_nonempty;

endmodule

// File: tb/tb_a23_copro_mp.sv
// Self-checking bench for a23_copro_mp (AREA_W=8, FAULT_DEPTH=4).
// Fault-capture expectations follow A23_COPRO_FAULT_FIFO_EN if defined.
module tb_a23_copro_mp;

  localparam int AREA_W      = 8;
  localparam int FAULT_DEPTH = 4;
  localparam logic [31:0] CPU_ID = 32'h4156_0300;

`ifdef A23_COPRO_FAULT_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_stall;
  logic [1:0]        copro_operation;
  logic [3:0]        copro_crn;
  logic [31:0]       copro_write_data;
  logic              fault;
  logic [7:0]        fault_status;
  logic [31:0]       fault_address;
  logic              cache_flush_done;
  logic [31:0]       copro_read_data;
  logic              cache_enable;
  logic              cache_flush;
  logic [AREA_W-1:0] cacheable_area;
  logic [AREA_W-1:0] updateable_area;
  logic [AREA_W-1:0] disruptive_area;
  logic              fault_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  a23_copro_mp #(
    .AREA_W      (AREA_W),
    .FAULT_DEPTH (FAULT_DEPTH),
    .CPU_ID      (CPU_ID)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_fetch_stall      (fetch_stall),
    .i_copro_operation  (copro_operation),
    .i_copro_crn        (copro_crn),
    .i_copro_write_data (copro_write_data),
    .i_fault            (fault),
    .i_fault_status     (fault_status),
    .i_fault_address    (fault_address),
    .i_cache_flush_done (cache_flush_done),
    .o_copro_read_data  (copro_read_data),
    .o_cache_enable     (cache_enable),
    .o_cache_flush      (cache_flush),
    .o_cacheable_area   (cacheable_area),
    .o_updateable_area  (updateable_area),
    .o_disruptive_area  (disruptive_area),
    .o_fault_pending    (fault_pending)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  crn;
    logic [31:0] wdata;
    logic        stall;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ce;
    logic [7:0]  exp_ca;
    logic [7:0]  exp_ua;
    logic [7:0]  exp_da;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] crn,
                              input logic [31:0] wdata, input logic stall,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_ce, input logic [7:0] exp_ca,
                              input logic [7:0] exp_ua, input logic [7:0] exp_da,
                              input string name);
    vec_t v;
    v.op = op; v.crn = crn; v.wdata = wdata; v.stall = stall;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_ce = exp_ce;
    v.exp_ca = exp_ca; v.exp_ua = exp_ua; v.exp_da = exp_da; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fetch_stall      = 1'b0;
    copro_operation  = 2'd0;
    copro_crn        = 4'd0;
    copro_write_data = 32'd0;
    fault            = 1'b0;
    fault_status     = 8'd0;
    fault_address    = 32'd0;
    cache_flush_done = 1'b0;
  endtask

  task automatic mcr(input logic [3:0] crn, input logic [31:0] data);
    copro_operation  = 2'd2;
    copro_crn        = crn;
    copro_write_data = data;
    step();
    set_idle();
  endtask

  task automatic mrc_check(input logic [3:0] crn, input logic [31:0] exp, input string name);
    copro_operation = 2'd1;
    copro_crn       = crn;
    step();
    check(name, copro_read_data, exp);
    set_idle();
  endtask

  task automatic push_fault(input logic [7:0] status, input logic [31:0] addr);
    fault         = 1'b1;
    fault_status  = status;
    fault_address = addr;
    step();
    set_idle();
  endtask

  initial begin
    // Register-port vectors: op, crn, wdata, stall, chk_rd, exp_rd, ce, cacheable, updateable, disruptive
    vecs.push_back(mk(2'd1, 4'd0, 32'd0,         1'b0, 1'b1, CPU_ID,   1'b0, 8'h00, 8'h00, 8'h00, "mrc0_cpu_id"));
    vecs.push_back(mk(2'd1, 4'd2, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc2_reset"));
    vecs.push_back(mk(2'd1, 4'd3, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc3_reset"));
    vecs.push_back(mk(2'd1, 4'd4, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc4_reset"));
    vecs.push_back(mk(2'd1, 4'd5, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc5_reset"));
    vecs.push_back(mk(2'd1, 4'd6, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc6_reset"));
    vecs.push_back(mk(2'd1, 4'd7, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc7_empty"));
    vecs.push_back(mk(2'd1, 4'd8, 32'd0,         1'b0, 1'b1, 32'd0,    1'b0, 8'h00, 8'h00, 8'h00, "mrc8_reset"));
    vecs.push_back(mk(2'd2, 4'd3, 32'hFFFF_FFA5, 1'b0, 1'b0, 32'd0,    1'b0, 8'hA5, 8'h00, 8'h00, "mcr3_a5"));
    vecs.push_back(mk(2'd1, 4'd3, 32'd0,         1'b0, 1'b1, 32'hA5,   1'b0, 8'hA5, 8'h00, 8'h00, "mrc3_a5"));
    vecs.push_back(mk(2'd2, 4'd4, 32'h0000_013C, 1'b0, 1'b0, 32'd0,    1'b0, 8'hA5, 8'h3C, 8'h00, "mcr4_3c"));
    vecs.push_back(mk(2'd1, 4'd4, 32'd0,         1'b0, 1'b1, 32'h3C,   1'b0, 8'hA5, 8'h3C, 8'h00, "mrc4_3c"));
    vecs.push_back(mk(2'd2, 4'd5, 32'h0000_0081, 1'b0, 1'b0, 32'd0,    1'b0, 8'hA5, 8'h3C, 8'h81, "mcr5_81"));
    vecs.push_back(mk(2'd1, 4'd5, 32'd0,         1'b0, 1'b1, 32'h81,   1'b0, 8'hA5, 8'h3C, 8'h81, "mrc5_81"));
    vecs.push_back(mk(2'd2, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,    1'b1, 8'hA5, 8'h3C, 8'h81, "mcr2_all"));
    vecs.push_back(mk(2'd1, 4'd2, 32'd0,         1'b0, 1'b1, 32'h7,    1'b1, 8'hA5, 8'h3C, 8'h81, "mrc2_7"));
    vecs.push_back(mk(2'd2, 4'd2, 32'd0,         1'b1, 1'b0, 32'd0,    1'b1, 8'hA5, 8'h3C, 8'h81, "mcr2_stalled"));
    vecs.push_back(mk(2'd1, 4'd2, 32'd0,         1'b0, 1'b1, 32'h7,    1'b1, 8'hA5, 8'h3C, 8'h81, "mrc2_after_stall"));
    vecs.push_back(mk(2'd1, 4'd0, 32'd0,         1'b1, 1'b1, 32'h7,    1'b1, 8'hA5, 8'h3C, 8'h81, "rd_hold_stalled"));
    vecs.push_back(mk(2'd2, 4'd9, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,    1'b1, 8'hA5, 8'h3C, 8'h81, "mcr9_ignored"));
    vecs.push_back(mk(2'd1, 4'd9, 32'd0,         1'b0, 1'b1, 32'd0,    1'b1, 8'hA5, 8'h3C, 8'h81, "mrc9_zero"));
    vecs.push_back(mk(2'd2, 4'd3, 32'd0,         1'b1, 1'b0, 32'd0,    1'b1, 8'hA5, 8'h3C, 8'h81, "mcr3_stalled"));
    vecs.push_back(mk(2'd2, 4'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0,    1'b0, 8'hA5, 8'h3C, 8'h81, "mcr2_6"));
    vecs.push_back(mk(2'd1, 4'd2, 32'd0,         1'b0, 1'b1, 32'h6,    1'b0, 8'hA5, 8'h3C, 8'h81, "mrc2_6"));

    // Reset state
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", copro_read_data, 32'd0);
    check("rst_cache_enable", cache_enable, 1'b0);
    check("rst_cache_flush", cache_flush, 1'b0);
    check("rst_cacheable", cacheable_area, 8'h00);
    check("rst_fault_pending", fault_pending, 1'b0);
    #2 rst_n = 1'b1;

    // Table-driven register-port vectors
    foreach (vecs[i]) begin
      fetch_stall      = vecs[i].stall;
      copro_operation  = vecs[i].op;
      copro_crn        = vecs[i].crn;
      copro_write_data = vecs[i].wdata;
      step();
      if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, copro_read_data, vecs[i].exp_rd);
      check({vecs[i].name, "_ce"}, cache_enable, vecs[i].exp_ce);
      check({vecs[i].name, "_ca"}, cacheable_area, vecs[i].exp_ca);
      check({vecs[i].name, "_ua"}, updateable_area, vecs[i].exp_ua);
      check({vecs[i].name, "_da"}, disruptive_area, vecs[i].exp_da);
      check({vecs[i].name, "_flush"}, cache_flush, 1'b0);
    end
    set_idle();

    // Five faults into a four-entry store
    for (int n = 1; n <= 5; n++) begin
      push_fault(8'(n), 32'h100 * n);
      check("push_pending", fault_pending, 1'b1);
    end
    mrc_check(4'd6, FIFO_MODE ? 32'h0000_0401 : 32'h0000_0105, "ovf_crn6");
    mrc_check(4'd8, FIFO_MODE ? 32'd1 : 32'd0, "ovf_crn8");
    mrc_check(4'd7, FIFO_MODE ? 32'h100 : 32'h500, "pop1");
    mrc_check(4'd7, FIFO_MODE ? 32'h200 : 32'h000, "pop2");
    mrc_check(4'd7, FIFO_MODE ? 32'h300 : 32'h000, "pop3");
    mrc_check(4'd7, FIFO_MODE ? 32'h400 : 32'h000, "pop4");
    check("drained_pending", fault_pending, 1'b0);
    mcr(4'd8, 32'd0);
    mrc_check(4'd8, 32'd0, "ovf_cleared");

    // Full store with simultaneous fault and CRn7 read
    for (int n = 1; n <= 4; n++) push_fault(8'h10 + 8'(n), 32'h1000 * n);
    copro_operation = 2'd1;
    copro_crn       = 4'd7;
    fault           = 1'b1;
    fault_status    = 8'h15;
    fault_address   = 32'h5000;
    step();
    check("simul_rd", copro_read_data, FIFO_MODE ? 32'h1000 : 32'h4000);
    set_idle();
    mrc_check(4'd6, FIFO_MODE ? 32'h0000_0412 : 32'h0000_0115, "simul_crn6");
    mrc_check(4'd8, 32'd0, "simul_no_ovf");
    mrc_check(4'd7, FIFO_MODE ? 32'h2000 : 32'h5000, "simul_pop1");
    mrc_check(4'd7, FIFO_MODE ? 32'h3000 : 32'h0000, "simul_pop2");
    mrc_check(4'd7, FIFO_MODE ? 32'h4000 : 32'h0000, "simul_pop3");
    mrc_check(4'd7, FIFO_MODE ? 32'h5000 : 32'h0000, "simul_pop4");
    check("simul_drained", fault_pending, 1'b0);

    // Flush handshake
    mcr(4'd1, 32'd0);
    check("flush_start", cache_flush, 1'b1);
    mcr(4'd1, 32'd0);
    check("flush_second_mcr", cache_flush, 1'b1);
    mrc_check(4'd8, 32'd2, "flush_busy_rd");
    fetch_stall      = 1'b1;
    cache_flush_done = 1'b1;
    step();
    check("flush_ack_stalled", cache_flush, 1'b0);
    set_idle();
    step();
    check("flush_stays_idle", cache_flush, 1'b0);
    mrc_check(4'd8, 32'd0, "flush_idle_rd");
    cache_flush_done = 1'b1;
    step();
    check("ack_in_idle", cache_flush, 1'b0);
    set_idle();

    // Asynchronous reset in the middle of a flush
    mcr(4'd2, 32'd1);
    check("pre_rst_ce", cache_enable, 1'b1);
    push_fault(8'h77, 32'h7700);
    mcr(4'd1, 32'd0);
    check("pre_rst_flush", cache_flush, 1'b1);
    mrc_check(4'd0, CPU_ID, "pre_rst_rd");
    rst_n = 1'b0;
    #2;
    check("async_rst_flush", cache_flush, 1'b0);
    check("async_rst_ce", cache_enable, 1'b0);
    check("async_rst_ca", cacheable_area, 8'h00);
    check("async_rst_rd", copro_read_data, 32'd0);
    check("async_rst_pending", fault_pending, 1'b0);
    #2 rst_n = 1'b1;
    step();
    cache_flush_done = 1'b1;
    step();
    check("late_ack_flush", cache_flush, 1'b0);
    set_idle();
    mrc_check(4'd8, 32'd0, "late_ack_crn8");
    mrc_check(4'd6, 32'd0, "post_rst_crn6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
